ifetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle MIPS datapath.
- Generates sequential fetch addresses and fetches from an instruction memory over a req/ack handshake.
- Buffers fetched words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts a branch/jump redirect from the datapath that flushes buffered and in-flight instructions.

---
 rtl/ifetch_queue.sv | 109 ++++++++++
 tb/tb_ifetch_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues sequential fetches over req/ack, queues {pc, word}
// in a small FIFO for decode, and flushes on branch/jump redirect.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  input  logic        instr_ready
);

  localparam int        AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] word;
  } entry_t;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n, pc_plus4, addr_n;
  logic [AW:0]   count, count_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  entry_t        fifo [DEPTH];
  entry_t        head;
  logic          fire, pop, push, flush, hold, req_n;

  assign pc_plus4 = fetch_pc + 32'd4;
  assign fire     = imem_req & imem_ack;
  assign hold     = imem_req & ~imem_ack;
  assign pop      = instr_valid & instr_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      // an unacked request cannot be withdrawn, so its data is drained and dropped
      flush      = 1'b1;
      fetch_pc_n = {redirect_pc[31:2], 2'b00};
      state_n    = hold ? DRAIN : FETCH;
    end else if (state == DRAIN) begin
      if (imem_ack) state_n = FETCH;
    end else if (fire) begin
      push       = 1'b1;
      fetch_pc_n = pc_plus4;
    end
    count_n = flush ? '0 : count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    // a held request keeps its address; a new one issues only into reserved space
    req_n   = hold | ((state_n == FETCH) && (count_n < FULL));
    addr_n  = hold ? imem_addr : fetch_pc_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      fetch_pc  <= fetch_pc_n;
      count     <= count_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (push) begin
      fifo[wr_ptr] <= '{pc: fetch_pc, pc4: pc_plus4, word: imem_rdata};
    end
  end

  assign head        = fifo[rd_ptr];
  assign instr_valid = (count != '0);
  assign instr       = head.word;
  assign instr_pc    = head.pc;
  assign instr_pc4   = head.pc4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: vector table, directed stall/redirect/reset sequences,
// and a randomized run against a queue-based reference model.
module tb_ifetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        imem_req, imem_ack, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, instr_pc4;

  logic        w_req, w_ack, w_redirect, w_valid, w_ready;
  logic [31:0] w_addr, w_rdata, w_rpc, w_instr, w_pc, w_pc4;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_pc4(instr_pc4), .instr_ready(instr_ready));

  // zero-wait memory for the wrap-around instance
  assign w_ack   = w_req;
  assign w_rdata = mw(w_addr);

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .redirect(w_redirect),
    .redirect_pc(w_rpc), .instr_valid(w_valid), .instr(w_instr),
    .instr_pc(w_pc), .instr_pc4(w_pc4), .instr_ready(w_ready));

  int nvec = 0, nfail = 0;
  int waits, wcnt, cur_wait, acks;
  bit rnd_wait;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // memory responder: ack after cur_wait stalled cycles
  task automatic mem_step();
    if (reset) begin
      imem_ack = 1'b0; wcnt = 0;
    end else if (imem_req) begin
      if (wcnt >= cur_wait) begin
        imem_ack = 1'b1; imem_rdata = mw(imem_addr); wcnt = 0; acks++;
        cur_wait = rnd_wait ? int'($urandom_range(0, 3)) : waits;
      end else begin
        imem_ack = 1'b0; wcnt++;
      end
    end else begin
      imem_ack = 1'b0; wcnt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; mem_step();
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    reset = 1'b0; acks = 0;
  endtask

  typedef struct {
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        wvalid;
    logic [31:0] wpc;
  } vec_t;

  vec_t vt [6];

  typedef struct { logic [31:0] pc; logic [31:0] word; } ment_t;
  ment_t       mq [$];
  logic [31:0] popped [$];
  logic [31:0] model_pc, last_addr;
  bit          pend_m, drain_m, after_rst, found, got_ack;
  int          n8;

  task automatic rec();
    if (instr_valid && instr_ready) popped.push_back(instr_pc);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; w_redirect = 1'b0; w_rpc = '0; w_ready = 1'b1;
    waits = 0; cur_wait = 0; wcnt = 0; rnd_wait = 0; acks = 0;

    // zero-wait streaming from reset; wrap instance checked in parallel
    vt[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b1, 32'h4,  1'b1, 32'h0, 1'b1, 32'hFFFF_FFF8};
    vt[3] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC};
    vt[4] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h8, 1'b1, 32'h0000_0000};
    vt[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC, 1'b1, 32'h0000_0004};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ei, ep4, wi, wp4;
      instr_ready = vt[i].ready;
      ei  = vt[i].valid  ? mw(vt[i].pc)           : 32'h0;
      ep4 = vt[i].valid  ? vt[i].pc + 32'd4       : 32'h0;
      wi  = vt[i].wvalid ? mw(vt[i].wpc)          : 32'h0;
      wp4 = vt[i].wvalid ? vt[i].wpc + 32'd4      : 32'h0;
      chk($sformatf("stream_c%0d", i),
          128'({imem_req, imem_req ? imem_addr : 32'h0, instr_valid, instr_pc, instr_pc4, instr}),
          128'({vt[i].req, vt[i].addr, vt[i].valid, vt[i].pc, ep4, ei}));
      chk($sformatf("wrap_c%0d", i), 128'({w_valid, w_pc, w_pc4, w_instr}),
          128'({vt[i].wvalid, vt[i].wpc, wp4, wi}));
      tick();
    end

    // stall: FIFO fills to DEPTH, request drops, then drains in order
    instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) tick();
    chk("stall_acks", 128'(acks), 128'(DEPTH));
    chk("stall_req_low", 128'({imem_req, instr_valid}), 128'({1'b0, 1'b1}));
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall_pop%0d", k), 128'({instr_valid, instr_pc, instr}),
          128'({1'b1, 32'(4 * k), mw(32'(4 * k))}));
      if (k == 1) chk("stall_reissue", 128'({imem_req, imem_addr}), 128'({1'b1, 32'h10}));
      tick();
    end

    // redirect during a waited request: old address held, its data dropped
    waits = 3; cur_wait = 3; instr_ready = 1'b1;
    do_reset();
    popped.delete(); found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
      else begin rec(); tick(); end
    end
    chk("drain_find_req8", 128'(found), 128'(1));
    rec(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    rec(); tick();
    redirect = 1'b0;
    got_ack = 1'b0;
    for (int k = 0; k < 10 && !got_ack; k++) begin
      chk("drain_hold_addr", 128'({imem_req, imem_addr}), 128'({1'b1, 32'h8}));
      if (imem_ack) got_ack = 1'b1;
      rec(); tick();
    end
    chk("drain_ack_seen", 128'(got_ack), 128'(1));
    chk("drain_next_addr", 128'({imem_req, imem_addr}), 128'({1'b1, 32'h100}));
    for (int k = 0; k < 20; k++) begin rec(); tick(); end
    chk("drain_pop_count", 128'(popped.size() >= 4), 128'(1));
    if (popped.size() >= 4) begin
      logic [31:0] ep [4];
      ep[0] = 32'h0; ep[1] = 32'h4; ep[2] = 32'h100; ep[3] = 32'h104;
      for (int i = 0; i < 4; i++) chk($sformatf("drain_seq%0d", i), 128'(popped[i]), 128'(ep[i]));
    end
    n8 = 0;
    foreach (popped[i]) if (popped[i] == 32'h8) n8++;
    chk("drain_no_pc8", 128'(n8), 128'(0));

    // redirect coinciding with ack: acked word dropped, low bits of target cleared
    waits = 0; cur_wait = 0; instr_ready = 1'b1;
    do_reset();
    tick(); tick(); tick();
    chk("rdack_ack_now", 128'({imem_req, imem_ack}), 128'({1'b1, 1'b1}));
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    chk("rdack_flushed", 128'({instr_valid, imem_req, imem_addr}), 128'({1'b0, 1'b1, 32'h200}));
    tick();
    chk("rdack_new_head", 128'({instr_valid, instr_pc, instr_pc4, instr}),
        128'({1'b1, 32'h200, 32'h204, mw(32'h200)}));

    // reset while a request is outstanding with two entries queued
    waits = 3; cur_wait = 3; instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (acks == 2 && imem_req && !imem_ack) found = 1'b1;
      else tick();
    end
    chk("rst_mid_setup", 128'({found, instr_valid}), 128'({1'b1, 1'b1}));
    reset = 1'b1;
    tick();
    chk("rst_mid_outputs", 128'({imem_req, instr_valid, instr, instr_pc, instr_pc4}), 128'(0));
    reset = 1'b0;
    chk("rst_mid_cycle0", 128'(imem_req), 128'(0));
    tick();
    chk("rst_mid_restart", 128'({imem_req, imem_addr}), 128'({1'b1, 32'h0}));

    // randomized run against the reference model
    rnd_wait = 1'b1; cur_wait = int'($urandom_range(0, 3));
    do_reset();
    mq.delete(); model_pc = 32'h0; pend_m = 1'b0; drain_m = 1'b0; after_rst = 1'b1; last_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_valid", 128'(instr_valid), 128'(mq.size() != 0));
      if (mq.size() != 0)
        chk("rnd_head", 128'({instr_pc, instr_pc4, instr}),
            128'({mq[0].pc, mq[0].pc + 32'd4, mq[0].word}));
      if (pend_m)
        chk("rnd_req_held", 128'({imem_req, imem_addr}), 128'({1'b1, last_addr}));
      else if (after_rst)
        chk("rnd_req_rst", 128'(imem_req), 128'(0));
      else begin
        chk("rnd_req", 128'(imem_req), 128'(mq.size() < DEPTH));
        if (imem_req) chk("rnd_addr", 128'(imem_addr), 128'(model_pc));
      end

      instr_ready = ($urandom_range(0, 9) < ((cyc % 400 < 200) ? 7 : 2));
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;

      if (instr_ready && mq.size() != 0) void'(mq.pop_front());
      if (redirect) begin
        mq.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
        if (imem_req && !imem_ack) drain_m = 1'b1;
        if (imem_req && imem_ack)  drain_m = 1'b0;
      end else if (imem_req && imem_ack) begin
        if (drain_m) drain_m = 1'b0;
        else begin
          mq.push_back('{model_pc, mw(model_pc)});
          model_pc = model_pc + 32'd4;
          chk("rnd_no_overflow", 128'(mq.size() <= DEPTH), 128'(1));
        end
      end
      pend_m    = imem_req && !imem_ack;
      last_addr = imem_addr;
      after_rst = 1'b0;
      tick();
    end
    redirect = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
